// File: rtl/demux_5ch_reg_if.sv
// Write-side bus of the 5-channel registered demux.
// Valid/ready handshake carrying a data word and a destination code.
interface demux_5ch_reg_if #(
  parameter int word_size = 8
);
  logic [word_size-1:0] data_in;
  logic [2:0]           sel;
  logic                 in_valid;
  logic                 in_ready;

  modport master (
    output data_in,
    output sel,
    output in_valid,
    input  in_ready
  );

  modport slave (
    input  data_in,
    input  sel,
    input  in_valid,
    output in_ready
  );
endinterface

// File: rtl/demux_5ch_reg.sv
// One-entry buffered demux into five registered outputs.
// Illegal selects drain silently and are tallied.
module demux_5ch_reg #(
  parameter int word_size = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  demux_5ch_reg_if.slave       bus,
  input  logic                 hold,
  input  logic                 clear_err,
  output logic [word_size-1:0] out_a,
  output logic [word_size-1:0] out_b,
  output logic [word_size-1:0] out_c,
  output logic [word_size-1:0] out_d,
  output logic [word_size-1:0] out_e,
  output logic [4:0]           load_strobe,
  output logic                 sel_err,
  output logic [3:0]           err_count,
  output logic                 pending
);

  logic [word_size-1:0] data_q;
  logic [2:0]           sel_q;
  logic                 drain;
  logic                 accept;
  logic                 illegal;
  logic [4:0]           hot;
  logic                 err_nxt;
  logic [3:0]           cnt_nxt;

  assign bus.in_ready = !pending || !hold;
  assign drain        = pending && !hold;
  assign accept       = bus.in_valid && bus.in_ready;

  // Destination decode of the held entry
  always_comb begin
    hot     = '0;
    illegal = 1'b0;
    case (sel_q)
      3'd0:    hot = 5'b00001;
      3'd1:    hot = 5'b00010;
      3'd2:    hot = 5'b00100;
      3'd3:    hot = 5'b01000;
      3'd4:    hot = 5'b10000;
      default: illegal = 1'b1;
    endcase
  end

  // Error flag/counter next state; a new error beats a clear
  always_comb begin
    err_nxt = sel_err;
    cnt_nxt = err_count;
    if (drain && illegal) begin
      err_nxt = 1'b1;
      if (clear_err)
        cnt_nxt = 4'd1;
      else if (err_count != 4'hf)
        cnt_nxt = err_count + 4'd1;
    end else if (clear_err) begin
      err_nxt = 1'b0;
      cnt_nxt = '0;
    end
  end

  // Holding entry, output registers, strobe and error state
  always_ff @(posedge clk) begin
    if (rst) begin
      data_q      <= '0;
      sel_q       <= '0;
      pending     <= 1'b0;
      out_a       <= '0;
      out_b       <= '0;
      out_c       <= '0;
      out_d       <= '0;
      out_e       <= '0;
      load_strobe <= '0;
      sel_err     <= 1'b0;
      err_count   <= '0;
    end else begin
      load_strobe <= drain ? hot : 5'b0;
      sel_err     <= err_nxt;
      err_count   <= cnt_nxt;
      if (drain) begin
        if (hot[0]) out_a <= data_q;
        if (hot[1]) out_b <= data_q;
        if (hot[2]) out_c <= data_q;
        if (hot[3]) out_d <= data_q;
        if (hot[4]) out_e <= data_q;
      end
      if (accept) begin
        data_q  <= bus.data_in;
        sel_q   <= bus.sel;
        pending <= 1'b1;
      end else if (drain) begin
        pending <= 1'b0;
      end
    end
  end

endmodule
